// File: rtl/sparc_ifu_waysel.sv
// Icache fill-way allocator: invalid-way-first, else LFSR way, with per-thread fill reservations.
// Optional macro IFU_WAYSEL_RSV_MASK_EN enables masking of ways reserved by other threads on the same set.
module sparc_ifu_waysel #(
    parameter int NTHR = 4,
    parameter int TIDW = 2,
    parameter int IDXW = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            se,
    input  logic            alloc_req,
    input  logic [TIDW-1:0] alloc_tid,
    input  logic [IDXW-1:0] alloc_idx,
    input  logic [3:0]      alloc_vbits,
    input  logic [1:0]      lfsr_out,
    output logic            lfsr_advance,
    output logic            alloc_ack,
    output logic [TIDW-1:0] ack_tid,
    output logic [1:0]      alloc_way,
    input  logic            fill_done,
    input  logic [TIDW-1:0] fill_tid,
    output logic [NTHR-1:0] rsv_busy
);

    logic [NTHR-1:0] busy;
    logic [NTHR-1:0] release_vec;
    logic [NTHR-1:0] busy_eff;
    logic [NTHR-1:0] busy_nxt;
    logic [3:0]      rsv_mask;
    logic [3:0]      cand;
    logic [1:0]      sel_way;
    logic            use_lfsr;
    logic            accept;

`ifdef IFU_WAYSEL_RSV_MASK_EN
    logic [IDXW-1:0] idx_r [NTHR];
    logic [1:0]      way_r [NTHR];
    logic            unused_sink;
    assign unused_sink = se;
`else
    logic            unused_sink;
    assign unused_sink = ^{se, alloc_idx};
`endif

    function automatic logic [1:0] lowest_way(input logic [3:0] v);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) w = 2'(i);
        end
        return w;
    endfunction

    assign rsv_busy = busy;

    // A thread releasing this cycle no longer blocks its own request nor masks others.
    always_comb begin
        release_vec = '0;
        if (fill_done) release_vec[fill_tid] = 1'b1;
        busy_eff = busy & ~release_vec;
        accept   = alloc_req & ~reset & ~busy_eff[alloc_tid];
        busy_nxt = busy_eff;
        if (accept) busy_nxt[alloc_tid] = 1'b1;
    end

    always_comb begin
        rsv_mask = 4'b0000;
`ifdef IFU_WAYSEL_RSV_MASK_EN
        for (int t = 0; t < NTHR; t++) begin
            if (TIDW'(t) != alloc_tid && busy_eff[t] && idx_r[t] == alloc_idx)
                rsv_mask[way_r[t]] = 1'b1;
        end
`endif
    end

    // At most NTHR-1 ways are masked, so the final fallback always finds a free way.
    always_comb begin
        cand     = ~alloc_vbits & ~rsv_mask;
        sel_way  = 2'd0;
        use_lfsr = 1'b0;
        if (cand != 4'b0000) begin
            sel_way = lowest_way(cand);
        end else if (!rsv_mask[lfsr_out]) begin
            sel_way  = lfsr_out;
            use_lfsr = 1'b1;
        end else begin
            sel_way  = lowest_way(~rsv_mask);
            use_lfsr = 1'b1;
        end
    end

    assign lfsr_advance = accept & use_lfsr;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy      <= '0;
            alloc_ack <= 1'b0;
            ack_tid   <= '0;
            alloc_way <= 2'd0;
`ifdef IFU_WAYSEL_RSV_MASK_EN
            for (int t = 0; t < NTHR; t++) begin
                idx_r[t] <= '0;
                way_r[t] <= 2'd0;
            end
`endif
        end else begin
            busy      <= busy_nxt;
            alloc_ack <= accept;
            if (accept) begin
                ack_tid   <= alloc_tid;
                alloc_way <= sel_way;
`ifdef IFU_WAYSEL_RSV_MASK_EN
                idx_r[alloc_tid] <= alloc_idx;
                way_r[alloc_tid] <= sel_way;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sparc_ifu_waysel.sv
// Directed scoreboard bench for sparc_ifu_waysel; expectations follow IFU_WAYSEL_RSV_MASK_EN when defined.
module tb_sparc_ifu_waysel;

    logic       clk = 1'b0;
    logic       reset;
    logic       se;
    logic       alloc_req;
    logic [1:0] alloc_tid;
    logic [6:0] alloc_idx;
    logic [3:0] alloc_vbits;
    logic [1:0] lfsr_out;
    logic       lfsr_advance;
    logic       alloc_ack;
    logic [1:0] ack_tid;
    logic [1:0] alloc_way;
    logic       fill_done;
    logic [1:0] fill_tid;
    logic [3:0] rsv_busy;

    int passed = 0;
    int total  = 0;
    logic [3:0] sb_q [$];
    logic [3:0] last_ack;

`ifdef IFU_WAYSEL_RSV_MASK_EN
    localparam logic [1:0] MASKED_WAY = 2'd0;
`else
    localparam logic [1:0] MASKED_WAY = 2'd1;
`endif

    always #5 clk = ~clk;

    sparc_ifu_waysel dut (
        .clk(clk), .reset(reset), .se(se),
        .alloc_req(alloc_req), .alloc_tid(alloc_tid), .alloc_idx(alloc_idx),
        .alloc_vbits(alloc_vbits), .lfsr_out(lfsr_out), .lfsr_advance(lfsr_advance),
        .alloc_ack(alloc_ack), .ack_tid(ack_tid), .alloc_way(alloc_way),
        .fill_done(fill_done), .fill_tid(fill_tid), .rsv_busy(rsv_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input string tag, input bit rst, input bit req, input logic [1:0] tid,
                        input logic [6:0] idx, input logic [3:0] vb, input logic [1:0] lf,
                        input bit fd, input logic [1:0] ftid, input bit exp_adv,
                        input bit exp_acc, input logic [1:0] exp_way, input logic [3:0] exp_busy);
        logic exp_ack;
        @(negedge clk);
        reset = rst; alloc_req = req; alloc_tid = tid; alloc_idx = idx;
        alloc_vbits = vb; lfsr_out = lf; fill_done = fd; fill_tid = ftid;
        #1;
        check({tag, ".adv"}, 32'(lfsr_advance), 32'(exp_adv));
        if (rst) begin
            sb_q.delete();
            last_ack = 4'h0;
        end else if (exp_acc) begin
            sb_q.push_back({tid, exp_way});
        end
        @(posedge clk);
        #1;
        exp_ack = (sb_q.size() != 0);
        check({tag, ".ack"}, 32'(alloc_ack), 32'(exp_ack));
        if (exp_ack) last_ack = sb_q.pop_front();
        check({tag, ".tid"}, 32'(ack_tid), 32'(last_ack[3:2]));
        check({tag, ".way"}, 32'(alloc_way), 32'(last_ack[1:0]));
        check({tag, ".busy"}, 32'(rsv_busy), 32'(exp_busy));
    endtask

    initial begin
        se = 1'b0; reset = 1'b1; alloc_req = 1'b0; alloc_tid = 2'd0; alloc_idx = 7'h0;
        alloc_vbits = 4'h0; lfsr_out = 2'd0; fill_done = 1'b0; fill_tid = 2'd0;
        last_ack = 4'h0;

        //   tag         rst req tid idx    vbits    lfsr fd ftid adv acc way  busy
        step("rst0",     1, 1, 2'd0, 7'h12, 4'b0000, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b0000);
        step("rst1",     1, 1, 2'd1, 7'h12, 4'b0000, 2'd3, 0, 2'd0, 0, 0, 2'd0, 4'b0000);
        step("inv_way",  0, 1, 2'd0, 7'h12, 4'b1011, 2'd0, 0, 2'd0, 0, 1, 2'd2, 4'b0001);
        step("lfsr_way", 0, 1, 2'd1, 7'h05, 4'b1111, 2'd3, 0, 2'd0, 1, 1, 2'd3, 4'b0011);
        step("rel0",     0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 1, 2'd0, 0, 0, 2'd0, 4'b0010);
        step("rel1",     0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 1, 2'd1, 0, 0, 2'd0, 4'b0000);
        step("t0_w3",    0, 1, 2'd0, 7'h12, 4'b1111, 2'd3, 0, 2'd0, 1, 1, 2'd3, 4'b0001);
        step("t2_w1",    0, 1, 2'd2, 7'h12, 4'b1111, 2'd1, 0, 2'd0, 1, 1, 2'd1, 4'b0101);
        step("masked",   0, 1, 2'd1, 7'h12, 4'b1111, 2'd1, 0, 2'd0, 1, 1, MASKED_WAY, 4'b0111);
        step("t3_w2",    0, 1, 2'd3, 7'h40, 4'b1111, 2'd2, 0, 2'd0, 1, 1, 2'd2, 4'b1111);
        step("same_rel", 0, 1, 2'd3, 7'h40, 4'b0111, 2'd0, 1, 2'd3, 0, 1, 2'd3, 4'b1111);
        step("drop",     0, 1, 2'd2, 7'h12, 4'b1111, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b1111);
        step("rel1b",    0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 1, 2'd1, 0, 0, 2'd0, 4'b1101);
        step("rel_idle", 0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 1, 2'd1, 0, 0, 2'd0, 4'b1101);
        step("t1_inv",   0, 1, 2'd1, 7'h12, 4'b0000, 2'd2, 0, 2'd0, 0, 1, 2'd0, 4'b1111);
        step("rel0b",    0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 1, 2'd0, 0, 0, 2'd0, 4'b1110);
        step("rst_busy", 1, 1, 2'd0, 7'h12, 4'b0000, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b0000);
        step("post_rst", 0, 1, 2'd2, 7'h33, 4'b1101, 2'd0, 0, 2'd0, 0, 1, 2'd1, 4'b0100);
        step("idle",     0, 0, 2'd0, 7'h00, 4'b0000, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b0100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sparc_ifu_waysel.md
Name: sparc_ifu_waysel

Overview:
- Icache fill-way allocator in the IFU miss path; direct consumer of the 5-bit replacement LFSR's 2-bit output, and producer of that LFSR's advance strobe.
- On an icache miss, picks the way to fill for the missing thread: an invalid way first, otherwise the pseudo-random LFSR way.
- Holds a per-thread reservation (index, way) until the fill completes, so concurrent misses to the same set do not target the same way.

Parameters:
- NTHR, 4, number of threads; one reservation slot per thread.
- TIDW, 2, thread-id width; must equal log2(NTHR).
- IDXW, 7, icache set-index width.

Ports:
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- se  input  1  scan enable; no functional effect
- alloc_req  input  1  miss allocation request, single-cycle pulse
- alloc_tid  input  TIDW  requesting thread
- alloc_idx  input  IDXW  set index of the miss
- alloc_vbits  input  4  valid bits of ways 3..0 of the indexed set; valid in the alloc_req cycle
- lfsr_out  input  2  random way from the replacement LFSR
- lfsr_advance  output  1  LFSR advance strobe, combinational
- alloc_ack  output  1  registered; way granted
- ack_tid  output  TIDW  thread for alloc_ack
- alloc_way  output  2  granted way
- fill_done  input  1  fill complete pulse
- fill_tid  input  TIDW  thread whose fill completed
- rsv_busy  output  NTHR  per-thread reservation outstanding

Behaviour:
- Reset:
  - busy, idx and way registers cleared.
  - alloc_ack=0, ack_tid=0, alloc_way=0, rsv_busy=0 from the cycle after reset is sampled high.
  - lfsr_advance=0 while reset=1.
  - alloc_req and fill_done are ignored while reset=1.
- Latency: request in cycle N, then alloc_ack=1 in cycle N+1 for exactly one cycle. ack_tid and alloc_way hold their value until the next ack.
- Release: fill_done in cycle N clears rsv_busy[fill_tid] at N+1. fill_done for a non-busy thread has no effect.
- Acceptance: a request is accepted iff rsv_busy[alloc_tid]==0 after same-cycle release. fill_done and alloc_req for the same tid in the same cycle → the request is accepted.
- Request from an already-busy thread:
  - dropped: no ack, no state change, lfsr_advance=0.
  - this is a protocol violation; the verification environment flags it.
- Reservation mask rsv_mask[3:0]: OR of the one-hot of way[t] over every thread t≠alloc_tid with busy[t]=1 and idx[t]==alloc_idx. A thread releasing in the same cycle is excluded from the mask.
- Selection, in priority order:
  - (1) cand = ~alloc_vbits & ~rsv_mask. If cand≠0, the lowest set bit of cand; lfsr_advance=0.
  - (2) else, if lfsr_out is not masked, lfsr_out; lfsr_advance=1.
  - (3) else, lowest unmasked way; lfsr_advance=1.
  - At most NTHR-1=3 ways can be masked, so an unmasked way always exists.
- lfsr_advance is asserted only in the cycle of an accepted request that reaches step (2) or (3). The LFSR therefore presents a new value from the next cycle.
- On accept: busy[tid]←1, idx[tid]←alloc_idx, way[tid]←selected way; this takes effect at N+1 together with the ack.
- Back-to-back requests from different threads are supported every cycle. The request at N+1 sees the reservation written at N+1 (registered state).

Optional Feature:
- Macro: IFU_WAYSEL_RSV_MASK_EN.
- Defined: reservation masking as described above.
- Undefined:
  - rsv_mask is forced to 0, so selection is invalid-first-else-lfsr_out.
  - idx registers are not implemented.
  - busy/ack tracking, same-cycle release and drop rules are unchanged.

Test Plan:
- Reset for 2 cycles with alloc_req=1 → no ack, lfsr_advance=0, rsv_busy=0000.
- tid=0, idx=0x12, vbits=1011 → ack at N+1, alloc_way=2, lfsr_advance=0, rsv_busy=0001.
- tid=1, idx=0x05, vbits=1111, lfsr_out=3 → alloc_way=3, lfsr_advance=1 in the request cycle.
- With the macro defined:
  - Setup: tid0 holds idx 0x12 way 3, tid2 holds idx 0x12 way 1.
  - Stimulus: tid1, idx=0x12, vbits=1111, lfsr_out=1.
  - Required response: alloc_way=0, lfsr_advance=1.
  - Same stimulus with the macro undefined → alloc_way=1.
- tid3 busy; fill_done(tid3) and alloc_req(tid3, vbits=0111) in the same cycle → accepted, alloc_way=3, rsv_busy[3] stays 1.
- tid2 busy, alloc_req(tid2) without fill_done → no ack, state unchanged. Reset asserted while 3 threads are busy → rsv_busy=0000 next cycle.
